// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way cache controller.
// Holds the controller state encoding and the tree pseudo-LRU helpers.
// The helpers work on a fixed 7-bit tree, which covers up to 8 ways.
// Callers pass the tree depth, $clog2(WAYS), as the levels argument.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RESP_GAP  = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_FILL      = 2'd3
  } cache_state_e;

  localparam int PLRU_MAX_BITS = 7;
  localparam int WAY_IDX_MAX_W = 3;

  // Walk the tree from the root. A node bit of 0 selects the lower half.
  function automatic logic [WAY_IDX_MAX_W-1:0] plru_victim(
    input logic [PLRU_MAX_BITS-1:0] bits,
    input int                       levels
  );
    logic [2:0] node;
    logic [2:0] way;
    logic       b;
    node = 3'd0;
    way  = 3'd0;
    for (int lvl = 0; lvl < 3; lvl++) begin
      if (lvl < levels) begin
        b    = bits[node];
        way  = {way[1:0], b};
        node = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
      end else begin
        b = 1'b0;
      end
    end
    return way;
  endfunction

  // Make every node on the accessed way's path point away from that way.
  function automatic logic [PLRU_MAX_BITS-1:0] plru_update(
    input logic [PLRU_MAX_BITS-1:0] bits,
    input logic [WAY_IDX_MAX_W-1:0] way,
    input int                       levels
  );
    logic [PLRU_MAX_BITS-1:0] nb;
    logic [2:0]               node;
    logic [2:0]               w;
    logic                     d;
    nb   = bits;
    node = 3'd0;
    w    = way;
    // Left-align the way index so that its path bits come out MSB first.
    for (int k = 0; k < 3; k++) begin
      if (k >= levels) begin
        w = {w[1:0], 1'b0};
      end else begin
        w = w;
      end
    end
    for (int lvl = 0; lvl < 3; lvl++) begin
      if (lvl < levels) begin
        d        = w[2];
        nb[node] = ~d;
        node     = {node[1:0], 1'b0} + 3'd1 + {2'b00, d};
        w        = {w[1:0], 1'b0};
      end else begin
        d = 1'b0;
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_chk.sv
// Protocol checks for cache_ctrl_nway.
// Only one way may report a hit when the controller samples way_hit.
module cache_ctrl_nway_chk #(
  parameter int WAYS = 4
) (
  input logic            clk,
  input logic            rst,
  input logic            chk_en,
  input logic [WAYS-1:0] way_hit
);

  a_hit_onehot: assert property (@(posedge clk) disable iff (rst)
    chk_en |-> $onehot0(way_hit))
    else $error("cache_ctrl_nway: more than one way_hit bit set");

endmodule

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU state: one read port and one update port.
// Both ports use set_idx.
module cache_plru
  import cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(SETS)-1:0] set_idx,
  input  logic                    upd_en,
  input  logic [$clog2(WAYS)-1:0] upd_way,
  output logic [$clog2(WAYS)-1:0] victim_way
);
  localparam int WW = $clog2(WAYS);

  logic [WAYS-2:0]              plru_q [SETS];
  logic [PLRU_MAX_BITS-1:0]     cur_bits_s;
  logic [PLRU_MAX_BITS-1:0]     new_bits_s;
  logic [WAY_IDX_MAX_W-1:0]     vic_s;
  logic                         unused_plru_s;

  // Read the indexed tree and compute its victim and its updated value.
  always_comb begin
    cur_bits_s = PLRU_MAX_BITS'(plru_q[set_idx]);
    vic_s      = plru_victim(cur_bits_s, WW);
    new_bits_s = plru_update(cur_bits_s, WAY_IDX_MAX_W'(upd_way), WW);
  end

  assign victim_way    = vic_s[WW-1:0];
  assign unused_plru_s = ^{vic_s, new_bits_s};

  // PLRU storage: cleared by reset, written on an access update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
      end
    end else if (upd_en) begin
      plru_q[set_idx] <= new_bits_s[WAYS-2:0];
    end else begin
      plru_q[set_idx] <= plru_q[set_idx];
    end
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// Control FSM for a write-back, write-allocate, WAYS-way set-associative L1.
// Victims are chosen by lowest invalid way, else by tree PLRU (cache_plru).
// The optional macro CACHE_PERF_CNT_EN enables the hit/miss/writeback counters.
// Without that macro, hit_cnt, miss_cnt and wb_cnt are tied to 0.
module cache_ctrl_nway
  import cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [$clog2(SETS)-1:0] set_idx,
  input  logic [WAYS-1:0]         way_hit,
  input  logic [WAYS-1:0]         way_valid,
  input  logic [WAYS-1:0]         way_dirty,
  input  logic                    pmem_resp,
  output logic                    mem_resp,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic                    pmem_addr_sel,
  output logic [$clog2(WAYS)-1:0] way_sel,
  output logic                    data_we,
  output logic                    data_src_sel,
  output logic                    tag_we,
  output logic                    dirty_set,
  output logic                    dirty_clr,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt,
  output logic [CNT_W-1:0]        wb_cnt
);
  localparam int WW = $clog2(WAYS);

  cache_state_e   state_q, state_d;
  logic [WW-1:0]  victim_q, victim_d;
  logic           refill_q, refill_d;   // next IDLE hit is a fill's re-check

  logic           req_s;
  logic [WW-1:0]  hit_way_s;
  logic [WW-1:0]  inv_way_s;
  logic           any_inv_s;
  logic [WW-1:0]  plru_way_s;
  logic [WW-1:0]  victim_s;
  logic           victim_dirty_s;
  logic           plru_upd_en_s;
  logic [WW-1:0]  plru_upd_way_s;
  logic           hit_evt_s, miss_evt_s, wb_evt_s;

  assign req_s     = mem_read | mem_write;
  assign any_inv_s = ~(&way_valid);

  // Lowest-index hit way and lowest-index invalid way.
  always_comb begin
    hit_way_s = '0;
    inv_way_s = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_hit[i]) begin
        hit_way_s = WW'(i);
      end else begin
        hit_way_s = hit_way_s;
      end
      if (!way_valid[i]) begin
        inv_way_s = WW'(i);
      end else begin
        inv_way_s = inv_way_s;
      end
    end
  end

  assign victim_s       = any_inv_s ? inv_way_s : plru_way_s;
  assign victim_dirty_s = way_valid[victim_s] & way_dirty[victim_s];

  cache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk        (clk),
    .rst        (rst),
    .set_idx    (set_idx),
    .upd_en     (plru_upd_en_s),
    .upd_way    (plru_upd_way_s),
    .victim_way (plru_way_s)
  );

  cache_ctrl_nway_chk #(.WAYS(WAYS)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .chk_en  ((state_q == ST_IDLE) && req_s),
    .way_hit (way_hit)
  );

  // State, latched victim and re-check flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      victim_q <= '0;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      refill_q <= refill_d;
    end
  end

  // Next-state and combinational outputs from state plus inputs.
  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    refill_d       = refill_q;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    pmem_addr_sel  = 1'b0;
    way_sel        = '0;
    data_we        = 1'b0;
    data_src_sel   = 1'b0;
    tag_we         = 1'b0;
    dirty_set      = 1'b0;
    dirty_clr      = 1'b0;
    plru_upd_en_s  = 1'b0;
    plru_upd_way_s = '0;
    hit_evt_s      = 1'b0;
    miss_evt_s     = 1'b0;
    wb_evt_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        refill_d = 1'b0;
        if (req_s && (|way_hit)) begin
          way_sel        = hit_way_s;
          mem_resp       = 1'b1;
          data_we        = mem_write;
          dirty_set      = mem_write;
          plru_upd_en_s  = 1'b1;
          plru_upd_way_s = hit_way_s;
          hit_evt_s      = ~refill_q;
          state_d        = ST_RESP_GAP;
        end else if (req_s) begin
          victim_d   = victim_s;
          miss_evt_s = 1'b1;
          state_d    = victim_dirty_s ? ST_WRITEBACK : ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (pmem_resp) begin
          wb_evt_s = 1'b1;
          state_d  = ST_FILL;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_FILL: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          data_we        = 1'b1;
          data_src_sel   = 1'b1;
          tag_we         = 1'b1;
          dirty_clr      = 1'b1;
          plru_upd_en_s  = 1'b1;
          plru_upd_way_s = victim_q;
          refill_d       = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_RESP_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  // Performance counters; they wrap at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_q  + CNT_W'(hit_evt_s);
      miss_cnt_q <= miss_cnt_q + CNT_W'(miss_evt_s);
      wb_cnt_q   <= wb_cnt_q   + CNT_W'(wb_evt_s);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`else
  logic unused_cnt_s;
  assign unused_cnt_s = ^{hit_evt_s, miss_evt_s, wb_evt_s};
  assign hit_cnt      = '0;
  assign miss_cnt     = '0;
  assign wb_cnt       = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Self-checking bench for cache_ctrl_nway (WAYS=4, SETS=16, CNT_W=4).
// The bench plays the CPU, the tag/valid/dirty datapath and physical memory.
// Each request becomes a cycle-by-cycle list of expected outputs.
module tb_cache_ctrl_nway;
  localparam int WAYS  = 4;
  localparam int SETS  = 16;
  localparam int CNT_W = 4;
  localparam int L     = 2;   // tree depth

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mem_read, mem_write, pmem_resp;
  logic [3:0] set_idx, way_hit, way_valid, way_dirty;
  logic       mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic [1:0] way_sel;
  logic       data_we, data_src_sel, tag_we, dirty_set, dirty_clr;
  logic [3:0] hit_cnt, miss_cnt, wb_cnt;

  cache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .set_idx(set_idx), .way_hit(way_hit), .way_valid(way_valid),
    .way_dirty(way_dirty), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel), .data_we(data_we),
    .data_src_sel(data_src_sel), .tag_we(tag_we), .dirty_set(dirty_set),
    .dirty_clr(dirty_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .wb_cnt(wb_cnt)
  );

  int errors = 0;
  int checks = 0;
  int hits = 0, misses = 0, wbs = 0;
  bit mvld [SETS][WAYS];
  bit mdrt [SETS][WAYS];
  int mtag [SETS][WAYS];
  int pl   [SETS][WAYS-1];
  int cur_tag = 0;

  function automatic logic [10:0] mk(input int mr, input int pr, input int pw,
                                     input int as, input int ws, input int dwe,
                                     input int src, input int twe, input int ds,
                                     input int dc);
    return {1'(mr), 1'(pr), 1'(pw), 1'(as), 2'(ws), 1'(dwe), 1'(src),
            1'(twe), 1'(ds), 1'(dc)};
  endfunction

  // The tree node at level l on way w's path is (2^l - 1) + (w >> (L-l)).
  function automatic int mvictim(input int s);
    int w;
    w = 0;
    for (int l = 0; l < L; l++) w = 2 * w + pl[s][(1 << l) - 1 + w];
    return w;
  endfunction

  task automatic plru_touch(input int s, input int w);
    for (int l = 0; l < L; l++)
      pl[s][(1 << l) - 1 + (w >> (L - l))] = 1 - ((w >> (L - l - 1)) & 1);
  endtask

  task automatic model_reset();
    hits = 0; misses = 0; wbs = 0;
    for (int s = 0; s < SETS; s++)
      for (int n = 0; n < WAYS - 1; n++) pl[s][n] = 0;
  endtask

  // One clock: drive at negedge, compare the outputs 2 time units later.
  task automatic cycle(input int rd, input int wr, input int s, input int presp,
                       input int rstv, input logic [10:0] exp, input string nm);
    logic [10:0] act;
    logic [11:0] ecnt, acnt;
    @(negedge clk);
    rst       = (rstv != 0);
    mem_read  = (rd != 0);
    mem_write = (wr != 0);
    set_idx   = 4'(s);
    pmem_resp = (presp != 0);
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w]   = mvld[s][w] && (mtag[s][w] == cur_tag);
      way_valid[w] = mvld[s][w];
      way_dirty[w] = mdrt[s][w];
    end
    #2;
    act = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, data_we,
           data_src_sel, tag_we, dirty_set, dirty_clr};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s outputs: got %b want %b at %0t", nm, act, exp, $time);
    end
`ifdef CACHE_PERF_CNT_EN
    ecnt = {4'(hits), 4'(misses), 4'(wbs)};
`else
    ecnt = 12'd0;
`endif
    acnt = {hit_cnt, miss_cnt, wb_cnt};
    checks++;
    if (acnt !== ecnt) begin
      errors++;
      $display("FAIL %s counters: got %h want %h at %0t", nm, acnt, ecnt, $time);
    end
  endtask

  // One complete CPU request, from acceptance through the response gap.
  task automatic do_txn(input int wr, input int s, input int tag, input int wl,
                        input int fl);
    int hw, v, rd;
    bit hitf, rf;
    rd = 1 - wr;
    cur_tag = tag;
    hitf = 0; hw = 0; rf = 0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (mvld[s][w] && mtag[s][w] == tag) begin hitf = 1; hw = w; end
    if (!hitf) begin
      v = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!mvld[s][w]) v = w;
      if (v < 0) v = mvictim(s);
      cycle(rd, wr, s, 0, 0, mk(0,0,0,0,0,0,0,0,0,0), "miss_detect");
      misses++;
      if (mvld[s][v] && mdrt[s][v]) begin
        for (int i = 1; i <= wl; i++) begin
          if (i < wl) cycle(rd, wr, s, 0, 0, mk(0,0,1,1,v,0,0,0,0,0), "wb_wait");
          else        cycle(rd, wr, s, 1, 0, mk(0,0,1,1,v,0,0,0,0,0), "wb_done");
        end
        wbs++;
      end
      for (int i = 1; i <= fl; i++) begin
        if (i < fl) cycle(rd, wr, s, 0, 0, mk(0,1,0,0,v,0,0,0,0,0), "fill_wait");
        else        cycle(rd, wr, s, 1, 0, mk(0,1,0,0,v,1,1,1,0,1), "fill_done");
      end
      mvld[s][v] = 1; mtag[s][v] = tag; mdrt[s][v] = 0;
      plru_touch(s, v);
      hw = v; rf = 1;
    end
    cycle(rd, wr, s, 0, 0, mk(1,0,0,0,hw,wr,0,0,wr,0), "hit");
    if (wr != 0) mdrt[s][hw] = 1;
    plru_touch(s, hw);
    if (!rf) hits++;
    cycle(rd, wr, s, 0, 0, mk(0,0,0,0,0,0,0,0,0,0), "resp_gap");
  endtask

  initial begin
    int s, n;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    set_idx = 4'd0; way_hit = 4'd0; way_valid = 4'd0; way_dirty = 4'd0;
    for (int i = 0; i < SETS; i++)
      for (int w = 0; w < WAYS; w++) begin
        mvld[i][w] = 0; mdrt[i][w] = 0; mtag[i][w] = 0;
      end
    model_reset();

    cycle(0, 0, 0, 0, 1, mk(0,0,0,0,0,0,0,0,0,0), "in_reset");
    cycle(0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,0), "reset_state");

    // Set 5: fill ways 0..3 in order; way 0 is written and so becomes dirty.
    do_txn(1, 5, 1, 1, 2);
    do_txn(0, 5, 2, 1, 3);
    do_txn(0, 5, 3, 1, 1);
    do_txn(1, 5, 4, 1, 5);
    checks++;
    if (mvictim(5) != 0) begin
      errors++;
      $display("FAIL model_plru_victim: got %0d want 0", mvictim(5));
    end
    // Dirty miss: way 0 is written back, then refilled.
    do_txn(0, 5, 5, 3, 2);
    checks++;
    if (wbs != 1) begin
      errors++;
      $display("FAIL model_wb_count: got %0d want 1", wbs);
    end
`ifdef CACHE_PERF_CNT_EN
    checks++;
    if (wb_cnt !== 4'd1 || miss_cnt !== 4'd5 || hit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL dirty_miss_counters: got %0d/%0d/%0d want 0/5/1",
               hit_cnt, miss_cnt, wb_cnt);
    end
`endif
    do_txn(0, 5, 3, 1, 1);   // read hit on way 2
    do_txn(1, 5, 2, 1, 1);   // write hit on way 1

    // rst during FILL: outputs drop and the counters clear in the next cycle.
    cur_tag = 9;
    cycle(1, 0, 7, 0, 0, mk(0,0,0,0,0,0,0,0,0,0), "rst_miss_detect");
    misses++;
    cycle(1, 0, 7, 0, 0, mk(0,1,0,0,0,0,0,0,0,0), "rst_fill_wait");
    cycle(1, 0, 7, 0, 0, mk(0,1,0,0,0,0,0,0,0,0), "rst_fill_wait");
    cycle(1, 0, 7, 0, 1, mk(0,1,0,0,0,0,0,0,0,0), "rst_in_fill");
    model_reset();
    cycle(0, 0, 7, 0, 0, mk(0,0,0,0,0,0,0,0,0,0), "after_rst");
    checks++;
    if (pmem_read !== 1'b0 || {hit_cnt, miss_cnt, wb_cnt} !== 12'd0) begin
      errors++;
      $display("FAIL after_rst_literal: got pmem_read=%b cnt=%h want 0 and 000",
               pmem_read, {hit_cnt, miss_cnt, wb_cnt});
    end

    // 17 hits on set 5 wrap a 4-bit hit counter to 1.
    for (int i = 0; i < 17; i++) do_txn(int'($urandom_range(0, 1)), 5,
                                        2 + int'($urandom_range(0, 3)), 1, 1);
    checks++;
    if ((hits % 16) != 1) begin
      errors++;
      $display("FAIL model_hit_wrap: got %0d want 1", hits % 16);
    end
`ifdef CACHE_PERF_CNT_EN
    checks++;
    if (hit_cnt !== 4'd1) begin
      errors++;
      $display("FAIL hit_cnt_wrap: got %0d want 1", hit_cnt);
    end
`else
    checks++;
    if (hit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL hit_cnt_tied: got %0d want 0", hit_cnt);
    end
`endif

    // Randomised traffic over a few sets with a small tag pool.
    for (int t = 0; t < 200; t++) begin
      n = int'($urandom_range(0, 2));
      for (int k = 0; k < n; k++)
        cycle(0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,0), "idle");
      s = int'($urandom_range(0, 4));
      if (s == 4) s = 7;
      do_txn(int'($urandom_range(0, 1)), s, 1 + int'($urandom_range(0, 5)),
             1 + int'($urandom_range(0, 3)), 1 + int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
